skewed_data_feeder: RTL and testbench
=====================================

// Module: skewed_data_feeder
// PURPOSE
//  Multi-lane, parametrised feeder for the systolic MAC array. Accepts a full operand tile
//  (LANES vectors of DEPTH elements) over a valid/ready load port. Streams one element per
//  lane per enabled step, MSB element first. Lane i is skewed by i steps, which gives the
//  diagonal wavefront the array needs. Sits between the tile buffer and the array edge PEs.
// PARAMETERS
//  DATA_W  8  element width in bits (signed)
//  DEPTH   7  elements per lane vector
//  LANES   4  number of output lanes (array rows/cols fed)
// PORTS
//  clk         in   1                    clock, rising edge
//  reset       in   1                    asynchronous, active-high
//  load_valid  in   1                    tile on load_data is valid
//  load_ready  out  1                    feeder can accept a tile
//  load_data   in   LANES*DEPTH*DATA_W   lane i = [(i+1)*DEPTH*DATA_W-1 -: DEPTH*DATA_W]; element 0 = MSBs
//  enable      in   1                    advance one step this cycle
//  data_out    out  LANES*DATA_W         signed; lane i = [(i+1)*DATA_W-1 -: DATA_W]
//  lane_valid  out  LANES                data_out lane i holds a real element (not skew padding)
//  busy        out  1                    FSM in STREAM
//  done        out  1                    one-cycle pulse with the final step of a tile
// BEHAVIOUR
//  - reset value: state IDLE, step counter 0, all storage 0, data_out 0, lane_valid 0, done 0, busy 0.
//  - FSM IDLE -> STREAM on load handshake (load_valid & load_ready); the tile is captured and step=0.
//  - Only in STREAM, on an edge with enable=1: step k is issued, with registered outputs visible the
//    next cycle. Lane i shows element (k-i) with lane_valid[i]=1 when 0 <= k-i < DEPTH;
//    otherwise it shows 0 with lane_valid[i]=0.
//  - Steps per tile: NSTEP = DEPTH+LANES-1 (k = 0..NSTEP-1). The counter width is $clog2(NSTEP).
//  - enable=0 in STREAM: the step is not issued, outputs and counter hold, and done stays 0.
//  - done=1 is registered alongside step NSTEP-1. On that edge the next state follows the
//    CONFIGURATION rules.
//  - In IDLE, data_out and lane_valid are driven 0 every cycle.
//  - Handshake: load_valid must hold and load_data must stay stable until accepted.
//    load_valid while load_ready=0 is ignored; there is no drop and no error.
//  - reset mid-stream aborts immediately: the tile is discarded, done is never pulsed, and
//    load_ready returns per IDLE.
//  - No arithmetic on data. Elements pass through bit-exact and are interpreted as signed.
// CONFIGURATION
//  Macro DOUBLE_BUFFER_EN:
//  - Undefined: single tile register. load_ready = (state==IDLE). After step NSTEP-1 the FSM
//    goes to IDLE, so there is at least one idle cycle between tiles.
//  - Defined: a shadow tile register is added, and load_ready = !shadow_full.
//    - A load in IDLE goes straight to active.
//    - A load in STREAM writes shadow and sets shadow_full.
//    - On the step NSTEP-1 edge, the next tile is taken in this order: shadow (if full), else a
//      load handshaking on that same edge. Either one becomes active with step=0 and the FSM
//      stays in STREAM. Otherwise the FSM goes to IDLE.
//    - Result: zero-bubble back-to-back tiles. Reset clears shadow_full.
// STRUCTURE
//  - Package systolic_pkg: the feeder_state_e enum {IDLE, STREAM}, default DATA_W, and the
//    function nstep(depth, lanes).
//  - Sub-module feeder_lane (params DATA_W, DEPTH, SKEW): a DEPTH-entry shift register that
//    loads in parallel and shifts MSB-first only when step >= SKEW. It outputs the element and
//    the valid flag.
//  - The top level holds the FSM, step counter, optional shadow register, and a generate loop
//    over LANES.
// TESTING  (DATA_W=8, DEPTH=7, LANES=4, NSTEP=10)
//  1. Assert reset with random inputs. Expect data_out=0, lane_valid=0, done=0, busy=0 and
//     load_ready=1 while reset is high.
//  2. Load lane i elements 0x{i}1..0x{i}7 with enable held high. Lane 0 shows 01..07 at steps
//     0-6, lane 3 shows 31..37 at steps 3-9, and the padding steps show 00 with lane_valid=0.
//     done pulses once with step 9.
//  3. Drop enable for 3 cycles after step 4. Outputs and lane_valid hold their step-4 values.
//     Resume gives step 5 and done still arrives after exactly 10 enabled steps.
//  4. Assert reset at step 4. Outputs clear asynchronously and done never pulses. A new tile
//     then streams correctly from step 0.
//  5. DOUBLE_BUFFER_EN: offer a second tile at step 2. It is accepted and load_ready drops.
//     Tile 2 step 0 follows tile 1 step 9 on the next enabled edge. Undefined: load_ready=0
//     until IDLE, with one idle cycle between tiles.
//  6. Lane 0 element 0 = 0x80, enable=1. data_out lane 0 reads -128 signed and the other lanes
//     read 0.

Source files
------------

// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : systolic_pkg
// Description : Shared types and helpers for the systolic array edge feeders.
// Revision    : 1.0 - initial release
// ============================================================================
package systolic_pkg;

    // Feeder control states
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } feeder_state_e;

    localparam int DEFAULT_DATA_W = 8;

    // Number of steps needed to drain a skewed tile
    function automatic int nstep(input int depth, input int lanes);
        return depth + lanes - 1;
    endfunction

    // Counter width able to hold 0..n-1 (never narrower than one bit)
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/feeder_lane.sv
`default_nettype none
// ============================================================================
// Module      : feeder_lane
// Description : One feeder lane. Parallel-loads a DEPTH-element vector and
//               shifts it out element 0 first, starting SKEW steps late.
// Revision    : 1.0 - initial release
// ============================================================================
module feeder_lane
    import systolic_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = 7,
    parameter int SKEW   = 0,
    parameter int STEP_W = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load_i,
    input  logic [DEPTH*DATA_W-1:0]   load_data_i,
    input  logic                      issue_i,
    input  logic                      clear_i,
    input  logic [STEP_W-1:0]         step_i,
    output logic signed [DATA_W-1:0]  elem_o,
    output logic                      valid_o
);

    logic [DATA_W-1:0] sr_q [DEPTH];
    logic [DATA_W-1:0] elem_q;
    logic              valid_q;
    logic signed [31:0] w_rel;
    logic              w_window;

    // Position of the current step relative to this lane's skew
    assign w_rel    = 32'(step_i) - 32'(SKEW);
    assign w_window = (w_rel >= 0) && (w_rel < DEPTH);

    // Shift register plus registered element/valid output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < DEPTH; j++) begin
                sr_q[j] <= '0;
            end
            elem_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            if (issue_i) begin
                if (w_window) begin
                    elem_q  <= sr_q[0];
                    valid_q <= 1'b1;
                end else begin
                    elem_q  <= '0;
                    valid_q <= 1'b0;
                end
            end else if (clear_i) begin
                elem_q  <= '0;
                valid_q <= 1'b0;
            end

            // A fresh load wins over a shift; the issued element above still
            // comes from the old contents, which makes back-to-back tiles seamless.
            if (load_i) begin
                for (int j = 0; j < DEPTH; j++) begin
                    sr_q[j] <= load_data_i[(DEPTH-j)*DATA_W-1 -: DATA_W];
                end
            end else if (issue_i && w_window) begin
                for (int j = 0; j < DEPTH - 1; j++) begin
                    sr_q[j] <= sr_q[j+1];
                end
                sr_q[DEPTH-1] <= '0;
            end
        end
    end

    assign elem_o  = elem_q;
    assign valid_o = valid_q;

endmodule
`default_nettype wire

// File: rtl/skewed_data_feeder.sv
`default_nettype none
// ============================================================================
// Module      : skewed_data_feeder
// Description : Multi-lane skewed operand feeder for the systolic MAC array.
//               Accepts a LANES x DEPTH tile over valid/ready and streams it
//               with lane i delayed by i steps (diagonal wavefront).
//               Optional macro DOUBLE_BUFFER_EN adds a shadow tile register
//               for zero-bubble back-to-back tiles.
// Revision    : 1.0 - initial release
// ============================================================================
module skewed_data_feeder
    import systolic_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = 7,
    parameter int LANES  = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            load_valid,
    output logic                            load_ready,
    input  logic [LANES*DEPTH*DATA_W-1:0]   load_data,
    input  logic                            enable,
    output logic signed [LANES*DATA_W-1:0]  data_out,
    output logic [LANES-1:0]                lane_valid,
    output logic                            busy,
    output logic                            done
);

    localparam int NSTEP  = nstep(DEPTH, LANES);
    localparam int STEP_W = cnt_w(NSTEP);
    localparam int TILE_W = LANES * DEPTH * DATA_W;
    localparam int LANE_W = DEPTH * DATA_W;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NSTEP - 1);

    feeder_state_e     state_q;
    logic [STEP_W-1:0] step_q;
    logic              done_q;

    logic              w_stream;
    logic              w_issue;
    logic              w_last;
    logic              w_hs;
    logic              w_load_active;
    logic [TILE_W-1:0] w_tile;

    assign w_stream = (state_q == STREAM);
    assign w_issue  = w_stream & enable;
    assign w_last   = w_issue & (step_q == LAST_STEP);
    assign w_hs     = load_valid & load_ready;

`ifdef DOUBLE_BUFFER_EN
    logic [TILE_W-1:0] shadow_q;
    logic              shadow_full_q;
    logic              w_to_shadow;

    assign load_ready  = ~shadow_full_q;
    // A load mid-stream parks in the shadow, except on the final step edge
    // where it can become the active tile directly.
    assign w_to_shadow   = w_hs & w_stream & ~w_last;
    assign w_load_active = (w_hs & ~w_stream) | (w_last & (shadow_full_q | w_hs));
    assign w_tile        = shadow_full_q ? shadow_q : load_data;

    // Shadow tile holds the next tile until the active one drains
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
        end else if (w_to_shadow) begin
            shadow_q      <= load_data;
            shadow_full_q <= 1'b1;
        end else if (w_last & shadow_full_q) begin
            shadow_full_q <= 1'b0;
        end
    end
`else
    assign load_ready    = ~w_stream;
    assign w_load_active = w_hs;
    assign w_tile        = load_data;
`endif

    // Control FSM: step counter, tile turnover and done pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            step_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= w_last;
            case (state_q)
                IDLE: begin
                    if (w_load_active) begin
                        state_q <= STREAM;
                        step_q  <= '0;
                    end
                end
                STREAM: begin
                    if (w_last) begin
                        step_q  <= '0;
                        state_q <= w_load_active ? STREAM : IDLE;
                    end else if (w_issue) begin
                        step_q <= step_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    step_q  <= '0;
                end
            endcase
        end
    end

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            logic signed [DATA_W-1:0] w_elem;

            feeder_lane #(
                .DATA_W (DATA_W),
                .DEPTH  (DEPTH),
                .SKEW   (i),
                .STEP_W (STEP_W)
            ) u_lane (
                .clk         (clk),
                .reset       (reset),
                .load_i      (w_load_active),
                .load_data_i (w_tile[(i+1)*LANE_W-1 -: LANE_W]),
                .issue_i     (w_issue),
                .clear_i     (~w_stream),
                .step_i      (step_q),
                .elem_o      (w_elem),
                .valid_o     (lane_valid[i])
            );

            assign data_out[(i+1)*DATA_W-1 -: DATA_W] = w_elem;
        end
    endgenerate

    assign busy = w_stream;
    assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_skewed_data_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_skewed_data_feeder
// Description : Scoreboard bench for skewed_data_feeder (DATA_W=8, DEPTH=7,
//               LANES=4). Driver pushes per-cycle expectations, monitor pops.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_skewed_data_feeder;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 7;
    localparam int LANES  = 4;
    localparam int NSTEP  = 10;
    localparam int TILE_W = LANES * DEPTH * DATA_W;
`ifdef DOUBLE_BUFFER_EN
    localparam logic RDY_STREAM = 1'b1;
`else
    localparam logic RDY_STREAM = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic load_valid;
    logic load_ready;
    logic [TILE_W-1:0] load_data;
    logic enable;
    logic signed [LANES*DATA_W-1:0] data_out;
    logic [LANES-1:0] lane_valid;
    logic busy;
    logic done;

    typedef struct packed {
        logic [LANES*DATA_W-1:0] d;
        logic [LANES-1:0]        v;
        logic                    done;
        logic                    busy;
        logic                    ready;
    } exp_t;

    exp_t sb_q[$];
    int n_vec = 0;
    int n_err = 0;
    logic [7:0] tiles [3][LANES][DEPTH];

    skewed_data_feeder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LANES(LANES)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .enable     (enable),
        .data_out   (data_out),
        .lane_valid (lane_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [TILE_W-1:0] pack_tile(input int t);
        logic [TILE_W-1:0] v;
        v = '0;
        for (int i = 0; i < LANES; i++)
            for (int j = 0; j < DEPTH; j++)
                v[i*DEPTH*DATA_W + (DEPTH-1-j)*DATA_W +: DATA_W] = tiles[t][i][j];
        return v;
    endfunction

    function automatic exp_t exp_step(input int t, input int k, input logic dn, input logic bz, input logic rd);
        exp_t e;
        e = '0;
        for (int i = 0; i < LANES; i++) begin
            if ((k - i) >= 0 && (k - i) < DEPTH) begin
                e.d[i*DATA_W +: DATA_W] = tiles[t][i][k-i];
                e.v[i] = 1'b1;
            end
        end
        e.done  = dn;
        e.busy  = bz;
        e.ready = rd;
        return e;
    endfunction

    function automatic exp_t exp_idle(input logic bz, input logic rd);
        exp_t e;
        e = '0;
        e.busy  = bz;
        e.ready = rd;
        return e;
    endfunction

    // Drive one cycle of inputs and queue what must be visible after the edge
    task automatic drive(input logic lv, input int t, input logic en, input exp_t e);
        @(negedge clk);
        load_valid = lv;
        load_data  = (t >= 0) ? pack_tile(t) : '0;
        enable     = en;
        sb_q.push_back(e);
    endtask

    task automatic stream_steps(input int t, input int k0, input int hold_at, input int hold_n);
        for (int k = k0; k < NSTEP; k++) begin
            drive(1'b0, -1, 1'b1, exp_step(t, k, k == NSTEP-1, k != NSTEP-1,
                                           (k == NSTEP-1) ? 1'b1 : RDY_STREAM));
            if (k == hold_at)
                for (int h = 0; h < hold_n; h++)
                    drive(1'b0, -1, 1'b0, exp_step(t, k, 1'b0, 1'b1, RDY_STREAM));
        end
        drive(1'b0, -1, 1'b0, exp_idle(1'b0, 1'b1));
    endtask

    task automatic run_tile(input int t, input int hold_at, input int hold_n);
        drive(1'b1, t, 1'b1, exp_idle(1'b1, RDY_STREAM));
        stream_steps(t, 0, hold_at, hold_n);
    endtask

    // Monitor: compare DUT outputs against queued expectations after each edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("data_out",   {32'b0, data_out},   {32'b0, e.d});
                check("lane_valid", {60'b0, lane_valid}, {60'b0, e.v});
                check("done",       {63'b0, done},       {63'b0, e.done});
                check("busy",       {63'b0, busy},       {63'b0, e.busy});
                check("load_ready", {63'b0, load_ready}, {63'b0, e.ready});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < LANES; i++)
            for (int j = 0; j < DEPTH; j++) begin
                tiles[0][i][j] = 8'((i << 4) | (j + 1));
                tiles[1][i][j] = 8'(((i + 8) << 4) | (j + 1));
                tiles[2][i][j] = 8'h00;
            end
        tiles[2][0][0] = 8'h80;

        // 1: reset with random inputs
        reset      = 1'b1;
        load_valid = 1'b0;
        enable     = 1'b0;
        load_data  = '0;
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            load_valid = 1'($urandom_range(0, 1));
            enable     = 1'($urandom_range(0, 1));
            for (int w = 0; w < TILE_W/32; w++) load_data[w*32 +: 32] = $urandom();
            @(posedge clk);
            #1;
            check("rst data_out",   {32'b0, data_out},   64'd0);
            check("rst lane_valid", {60'b0, lane_valid}, 64'd0);
            check("rst done",       {63'b0, done},       64'd0);
            check("rst busy",       {63'b0, busy},       64'd0);
            check("rst load_ready", {63'b0, load_ready}, 64'd1);
        end
        @(negedge clk);
        reset      = 1'b0;
        load_valid = 1'b0;
        enable     = 1'b0;

        // 2: basic tile with enable held high
        run_tile(0, -1, 0);

        // 3: enable dropped for 3 cycles after step 4
        run_tile(0, 4, 3);

        // 4: reset at step 4 aborts the tile
        drive(1'b1, 0, 1'b1, exp_idle(1'b1, RDY_STREAM));
        for (int k = 0; k <= 4; k++)
            drive(1'b0, -1, 1'b1, exp_step(0, k, 1'b0, 1'b1, RDY_STREAM));
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("abort data_out",   {32'b0, data_out},   64'd0);
        check("abort lane_valid", {60'b0, lane_valid}, 64'd0);
        check("abort busy",       {63'b0, busy},       64'd0);
        check("abort load_ready", {63'b0, load_ready}, 64'd1);
        @(posedge clk);
        #2;
        check("abort done",       {63'b0, done},       64'd0);
        @(negedge clk);
        reset      = 1'b0;
        enable     = 1'b0;
        load_valid = 1'b0;
        run_tile(1, -1, 0);

        // 5: second tile offered at step 2
`ifdef DOUBLE_BUFFER_EN
        drive(1'b1, 0, 1'b1, exp_idle(1'b1, 1'b1));
        for (int k = 0; k < NSTEP; k++) begin
            if (k == 2)
                drive(1'b1, 1, 1'b1, exp_step(0, k, 1'b0, 1'b1, 1'b0));
            else
                drive(1'b0, -1, 1'b1, exp_step(0, k, k == NSTEP-1, 1'b1, (k < 2) || (k == NSTEP-1)));
        end
        stream_steps(1, 0, -1, 0);
`else
        drive(1'b1, 0, 1'b1, exp_idle(1'b1, 1'b0));
        for (int k = 0; k < NSTEP; k++) begin
            if (k < 2)
                drive(1'b0, -1, 1'b1, exp_step(0, k, 1'b0, 1'b1, 1'b0));
            else
                drive(1'b1, 1, 1'b1, exp_step(0, k, k == NSTEP-1, k != NSTEP-1, k == NSTEP-1));
        end
        drive(1'b1, 1, 1'b1, exp_idle(1'b1, 1'b0));
        stream_steps(1, 0, -1, 0);
`endif

        // 6: signed extreme on lane 0
        drive(1'b1, 2, 1'b1, exp_idle(1'b1, RDY_STREAM));
        drive(1'b0, -1, 1'b1, exp_step(2, 0, 1'b0, 1'b1, RDY_STREAM));
        @(posedge clk);
        #3;
        check("lane0 signed", 64'($signed(data_out[7:0])), 64'(-128));
        check("lanes1-3 zero", {40'b0, data_out[31:8]}, 64'd0);
        stream_steps(2, 1, -1, 0);

        @(posedge clk);
        #3;
        check("scoreboard drained", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
